// File: rtl/poly_add3_seq.sv
// poly_add3_seq: sequences v = y + msg_poly + e2 (mod q) over one polynomial, one coefficient per cycle
module poly_add3_seq #(
  parameter int DATA_WID = 12,
  parameter int N_COEF = 256,
  parameter int ADDR_WID = 8,
  parameter int Q = 3329
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                rd_en,
  output logic [ADDR_WID-1:0] rd_addr,
  input  logic [DATA_WID-1:0] y_coef,
  input  logic [DATA_WID-1:0] m_coef,
  input  logic [DATA_WID-1:0] e_coef,
  output logic                wr_en,
  output logic [ADDR_WID-1:0] wr_addr,
  output logic [DATA_WID-1:0] wr_data,
  output logic                busy,
  output logic                done,
  output logic                range_err
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;
  localparam logic [DATA_WID-1:0] QD = DATA_WID'(Q);
  localparam logic [DATA_WID:0] QW = (DATA_WID+1)'(Q);
  state_t state, nxt;
  logic [1:0] dcnt;
  logic v0, v1, last;
  logic [ADDR_WID-1:0] a0, a1;
  logic [DATA_WID-1:0] s1, e1, red_a, red_b;
  logic [DATA_WID:0] sum_a, sum_b;
  assign last = rd_addr == ADDR_WID'(N_COEF - 1);
  always_comb begin
    nxt = state == IDLE ? (start ? ISSUE : IDLE) :
          state == ISSUE ? (last ? DRAIN : ISSUE) :
          state == DRAIN ? (dcnt == 2'd2 ? FIN : DRAIN) : IDLE;
    rd_en = state == ISSUE;
    busy = state == ISSUE || state == DRAIN;
    done = state == FIN;
  end
  // Carry-out stays in the compare; only one subtraction per stage
  always_comb begin
    sum_a = {1'b0, y_coef} + {1'b0, m_coef};
    red_a = sum_a >= QW ? DATA_WID'(sum_a - QW) : sum_a[DATA_WID-1:0];
    sum_b = {1'b0, s1} + {1'b0, e1};
    red_b = sum_b >= QW ? DATA_WID'(sum_b - QW) : sum_b[DATA_WID-1:0];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rd_addr <= '0;
      dcnt <= '0;
      v0 <= 1'b0;
      v1 <= 1'b0;
      a0 <= '0;
      a1 <= '0;
      s1 <= '0;
      e1 <= '0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      range_err <= 1'b0;
    end else begin
      state <= nxt;
      rd_addr <= state == IDLE ? '0 : (state == ISSUE && !last) ? rd_addr + 1'b1 : rd_addr;
      dcnt <= state == DRAIN ? dcnt + 2'd1 : 2'd0;
      v0 <= rd_en;
      a0 <= rd_addr;
      v1 <= v0;
      a1 <= a0;
      s1 <= red_a;
      e1 <= e_coef;
      wr_en <= v1;
      wr_addr <= a1;
      wr_data <= red_b;
      range_err <= (state == IDLE && start) ? 1'b0 :
                   range_err | (v0 && (y_coef >= QD || m_coef >= QD || e_coef >= QD));
    end
  end
endmodule

// File: tb/tb_poly_add3_seq.sv
// tb_poly_add3_seq: randomized and directed passes checked against an arithmetic reference model
module tb_poly_add3_seq;
  localparam int Q = 3329;
  localparam int LAST = 261;
  logic clk = 0, rst_n = 0, start = 0;
  logic rd_en, wr_en, busy, done, range_err;
  logic [7:0] rd_addr, wr_addr;
  logic [11:0] y_coef = 0, m_coef = 0, e_coef = 0, wr_data;
  int ymem[256], mmem[256], emem[256];
  bit rd_l[LAST+1], busy_l[LAST+1], done_l[LAST+1], rerr_l[LAST+1], wr_l[LAST+1];
  int wa_q[$], wd_q[$];
  int n_wr, n_bad, n_rd, n_busy, n_done, done_cyc, first_rd, first_wr, rerr_first, n_rerr;
  int bad_got, bad_want;
  bit ab_any;
  int vectors = 0, fails = 0;

  poly_add3_seq dut (.clk(clk), .rst_n(rst_n), .start(start), .rd_en(rd_en), .rd_addr(rd_addr),
    .y_coef(y_coef), .m_coef(m_coef), .e_coef(e_coef), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done), .range_err(range_err));

  always #5 clk = ~clk;

  always @(posedge clk) if (rd_en) begin
    y_coef <= 12'(ymem[rd_addr]);
    m_coef <= 12'(mmem[rd_addr]);
    e_coef <= 12'(emem[rd_addr]);
  end

  function automatic int expv(int i);
    int s, t;
    if (ymem[i] < Q && mmem[i] < Q && emem[i] < Q) return (ymem[i] + mmem[i] + emem[i]) % Q;
    s = ymem[i] + mmem[i];
    s = (s >= Q ? s - Q : s) % 4096;
    t = s + emem[i];
    return (t >= Q ? t - Q : t) % 4096;
  endfunction

  task automatic fill(input int mode);
    for (int i = 0; i < 256; i++) begin
      ymem[i] = mode == 0 ? 0 : mode == 1 ? i : mode == 2 ? 3328 : mode == 3 ? 2000 : $urandom_range(0, Q-1);
      mmem[i] = mode == 0 ? 0 : mode == 1 ? 1 : mode == 2 ? 3328 : mode == 3 ? 1329 : $urandom_range(0, Q-1);
      emem[i] = mode == 0 ? 0 : mode == 1 ? 2 : mode == 2 ? 3328 : mode == 3 ? 0 : $urandom_range(0, Q-1);
    end
  endtask

  // Entered at a falling edge; start is sampled at edge 0, cycle c is sampled at the c-th falling edge after it
  task automatic do_pass(input int xa, input int xb, input int abort_at);
    wa_q.delete(); wd_q.delete();
    {n_rd, n_busy, n_done, done_cyc, first_rd, first_wr, rerr_first, n_rerr, ab_any} = '0;
    start = 1;
    @(negedge clk);
    start = 0;
    for (int c = 1; c <= LAST; c++) begin
      if (c == abort_at) begin
        rst_n = 0;
        #1;
        ab_any = wr_en | busy | done;
      end
      rd_l[c] = rd_en; busy_l[c] = busy; done_l[c] = done; rerr_l[c] = range_err; wr_l[c] = wr_en;
      n_rd += int'(rd_en); n_busy += int'(busy); n_rerr += int'(range_err);
      if (rd_en && first_rd == 0) first_rd = c;
      if (wr_en && first_wr == 0) first_wr = c;
      if (range_err && rerr_first == 0) rerr_first = c;
      if (done) begin n_done++; done_cyc = c; end
      if (wr_en) begin wa_q.push_back(int'(wr_addr)); wd_q.push_back(int'(wr_data)); end
      start = (c == xa || c == xb);
      if (c < LAST) @(negedge clk);
    end
    n_wr = wa_q.size();
    n_bad = 0;
    foreach (wa_q[j]) if (wa_q[j] != j || wd_q[j] != expv(j)) begin
      if (n_bad == 0) begin bad_got = wd_q[j]; bad_want = expv(j); end
      n_bad++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if ({rd_en, wr_en, busy, done, range_err} !== 5'b0) begin
      fails++; $display("FAIL reset_outputs: got %b want 00000", {rd_en, wr_en, busy, done, range_err});
    end
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_zero();
    fill(0);
    do_pass(0, 0, 0);
    vectors++; if (n_wr !== 256) begin fails++; $display("FAIL zero_nwr: got %0d want 256", n_wr); end
    vectors++; if (n_bad !== 0) begin fails++; $display("FAIL zero_data: got %0d want %0d", bad_got, bad_want); end
    vectors++; if (n_done !== 1 || done_cyc !== 260) begin fails++; $display("FAIL zero_done: got %0d pulses at %0d want 1 at 260", n_done, done_cyc); end
    vectors++; if (n_busy !== 259 || !busy_l[1] || !busy_l[259] || busy_l[260]) begin fails++; $display("FAIL zero_busy: got %0d cycles want 259 (1..259)", n_busy); end
    vectors++; if (first_rd !== 1 || first_wr !== 4) begin fails++; $display("FAIL zero_latency: got rd %0d wr %0d want rd 1 wr 4", first_rd, first_wr); end
  endtask

  task automatic test_ramp();
    fill(1);
    do_pass(0, 0, 0);
    vectors++; if (n_bad !== 0 || n_wr !== 256) begin fails++; $display("FAIL ramp_data: got %0d want %0d (%0d writes)", bad_got, bad_want, n_wr); end
    vectors++; if (first_wr - first_rd !== 3) begin fails++; $display("FAIL ramp_latency: got %0d want 3", first_wr - first_rd); end
    vectors++; if (n_rd !== 256) begin fails++; $display("FAIL ramp_nrd: got %0d want 256", n_rd); end
  endtask

  task automatic test_wrap();
    fill(2);
    do_pass(0, 0, 0);
    vectors++; if (n_wr !== 256 || wd_q[0] !== 3326 || n_bad !== 0) begin fails++; $display("FAIL wrap_3328: got %0d want 3326", wd_q[0]); end
    vectors++; if (rerr_l[LAST] !== 1'b0) begin fails++; $display("FAIL wrap_rerr: got %0d want 0", rerr_l[LAST]); end
    fill(3);
    do_pass(0, 0, 0);
    vectors++; if (n_wr !== 256 || wd_q[5] !== 0 || n_bad !== 0) begin fails++; $display("FAIL wrap_zero: got %0d want 0", wd_q[5]); end
  endtask

  task automatic test_ignore_start();
    fill(4);
    do_pass(5, 100, 0);
    vectors++; if (n_wr !== 256 || n_bad !== 0) begin fails++; $display("FAIL ignore_writes: got %0d writes %0d bad want 256 0", n_wr, n_bad); end
    vectors++; if (n_done !== 1 || done_cyc !== 260) begin fails++; $display("FAIL ignore_done: got %0d at %0d want 1 at 260", n_done, done_cyc); end
  endtask

  task automatic test_back_to_back();
    fill(4);
    do_pass(260, 0, 0);
    vectors++; if (n_wr !== 256 || n_bad !== 0 || done_cyc !== 260) begin fails++; $display("FAIL b2b_first: got %0d writes done %0d want 256 260", n_wr, done_cyc); end
    do_pass(0, 0, 0);
    vectors++; if (n_wr !== 256 || n_bad !== 0 || n_done !== 1 || done_cyc !== 260) begin fails++; $display("FAIL b2b_second: got %0d writes done %0d want 256 260", n_wr, done_cyc); end
  endtask

  task automatic test_reset_mid();
    int late;
    fill(4);
    do_pass(0, 0, 50);
    late = 0;
    for (int c = 50; c <= LAST; c++) late += int'(busy_l[c]) + int'(done_l[c]) + int'(wr_l[c]);
    vectors++; if (ab_any !== 1'b0) begin fails++; $display("FAIL abort_immediate: got %0d want 0", ab_any); end
    vectors++; if (late !== 0 || n_wr !== 46) begin fails++; $display("FAIL abort_quiet: got %0d late strobes %0d writes want 0 46", late, n_wr); end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    fill(4);
    do_pass(0, 0, 0);
    vectors++; if (n_wr !== 256 || n_bad !== 0 || done_cyc !== 260) begin fails++; $display("FAIL abort_recover: got %0d writes %0d bad want 256 0", n_wr, n_bad); end
  endtask

  task automatic test_range();
    fill(4);
    ymem[7] = 3500;
    do_pass(0, 0, 0);
    vectors++; if (rerr_l[8] !== 1'b0 || (rerr_first != 9 && rerr_first != 10)) begin fails++; $display("FAIL range_set: got first %0d want 9 or 10", rerr_first); end
    vectors++; if (n_rerr !== LAST - rerr_first + 1) begin fails++; $display("FAIL range_sticky: got %0d want %0d", n_rerr, LAST - rerr_first + 1); end
    vectors++; if (n_wr !== 256 || n_bad !== 0) begin fails++; $display("FAIL range_writes: got %0d want %0d", bad_got, bad_want); end
    fill(4);
    do_pass(0, 0, 0);
    vectors++; if (rerr_l[1] !== 1'b0 || rerr_l[LAST] !== 1'b0) begin fails++; $display("FAIL range_clear: got %0d want 0", rerr_l[1]); end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_ramp();
    test_wrap();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_range();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule

// File: doc/poly_add3_seq.md
Name: poly_add3_seq

Overview:
Sequencer for the Kyber three-operand coefficient addition v = y + msg_poly + e2 (mod q) over one 256-coefficient polynomial. Walks a coefficient index, issues synchronous reads to three operand memories and streams operands through two chained ripple/CLA-style 12-bit adders. Each adder is followed by a conditional subtract-q, and results are written back with address. Sits between the NTT/INTT output buffers and the ciphertext compress stage of encapsulation.

Parameters:
DATA_WID, 12, coefficient width in bits
N_COEF, 256, coefficients per polynomial
ADDR_WID, 8, coefficient address width, equal to log2(N_COEF)
Q, 3329, modulus

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begin a pass; ignored unless IDLE
rd_en  out  1  read strobe to all three operand memories
rd_addr  out  ADDR_WID  coefficient index being read
y_coef  in  DATA_WID  y[rd_addr], valid one cycle after rd_en
m_coef  in  DATA_WID  msg_poly[rd_addr], valid one cycle after rd_en
e_coef  in  DATA_WID  e2[rd_addr], valid one cycle after rd_en
wr_en  out  1  result write strobe
wr_addr  out  ADDR_WID  result index
wr_data  out  DATA_WID  (y+m+e) mod Q
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse after the last write
range_err  out  1  sticky; set if any operand is >= Q during the pass

Behaviour:
- Reset is asynchronous on the rst_n fall. Every output is 0 on reset, the FSM goes to IDLE and all pipeline valid bits are cleared. Reset mid-pass aborts with no further wr_en and no done.
- The FSM has four states: IDLE, ISSUE, DRAIN, FIN.
  - IDLE, start=1 -> ISSUE. Clear rd_addr to 0 and clear range_err.
  - ISSUE: rd_en=1, rd_addr increments each cycle. Stay for exactly N_COEF cycles, then -> DRAIN after the cycle with rd_addr=N_COEF-1. rd_addr does not wrap within a pass.
  - DRAIN: rd_en=0. Stay until the pipeline is empty, which is 3 cycles.
  - FIN: done=1 for one cycle, busy=0, then -> IDLE.
- Pipeline, where k is the cycle in which rd_en=1 with rd_addr=i:
  - k+1: memory data is valid. Adder A computes s = y+m as a DATA_WID+1-bit sum. If s >= Q, s -= Q. Register into stage 1 at the end of k+1.
  - k+2: adder B computes t = s1+e as a DATA_WID+1-bit sum. If t >= Q, t -= Q. Register into stage 2, which drives wr_data, at the end of k+2.
  - k+3: wr_en=1, wr_addr=i, wr_data=t.
  - Address delay line: 3 registers, carried alongside the valid bits.
- Throughput is 1 coefficient/cycle. A pass from accepted start to done is N_COEF+4 cycles: start at edge 0, first rd_en in cycle 1, last wr_en in cycle N_COEF+3, done in cycle N_COEF+4.
- Arithmetic:
  - Operands are 12-bit unsigned.
  - The carry-out bit of each adder is the 13th bit of the sum and takes part in the >=Q compare.
  - Each stage performs one conditional subtraction only. Results are correct for operands < Q.
  - If an operand is >= Q, wr_data is the single-subtract value (not the true residue) and range_err is set. The pass still completes.
- busy is high in ISSUE and DRAIN, and low in IDLE and FIN. A start while busy or in FIN is ignored, with no restart.
- wr_en is never asserted outside a pass. Exactly N_COEF writes per pass, in ascending addresses 0..N_COEF-1.
- Back-to-back: start may be asserted in the cycle after done. The new pass starts normally.

Test Plan:
- Reset then start with y=m=e=0 for all i -> 256 writes, wr_data=0, addr 0..255 in order. done pulses once at cycle 260 after start. busy is high in cycles 1..259.
- y[i]=i, m[i]=1, e[i]=2 -> wr_data[i]=i+3 for all i (all < Q). First wr_en arrives exactly 3 cycles after the first rd_en.
- Wrap case: y=3328, m=3328, e=3328 at all i -> stage 1 gives 3327 and wr_data=3326. Also y=2000, m=1329, e=0 -> wr_data=0.
- Assert start again at cycles 5 and 100 of a pass -> ignored. Exactly 256 writes occur and done is single. Then start in the cycle after done -> second pass completes identically.
- Drop rst_n low at cycle 50 of a pass -> wr_en, busy and done are 0 immediately and stay 0. After release, start -> a full, correct 256-coefficient pass.
- y[7]=3500, other operands valid -> range_err=1 from the cycle after the read of index 7 and remains set until the next accepted start. All 256 writes still occur.
